// File: rtl/locked_reg_access_ctrl.sv
// Serialises privileged accesses to a downstream lockable register and answers each one with a status response.
// Grant decisions are made at acceptance so the strobes come straight from flops during ISSUE.
module locked_reg_access_ctrl #(
    parameter int DW          = 16,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    input  logic          req_trusted,
    input  logic          debug_en,
    output logic [DW-1:0] Data_in,
    output logic          write,
    output logic          Lock,
    output logic          debug_mode,
    output logic          trusted,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_status,
    output logic [DW-1:0] rsp_data,
    output logic          lock_shadow,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_LOCK  = 2'b01;
    localparam logic [1:0] OP_DBG   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_LOCKED = 2'b01;
    localparam logic [1:0] ST_DENIED = 2'b10;

    localparam logic [7:0] TO_LAST = 8'(RSP_TIMEOUT - 1);

    state_t        state;
    logic [DW-1:0] data_shadow;
    logic [7:0]    rsp_cnt;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            Data_in     <= '0;
            write       <= 1'b0;
            Lock        <= 1'b0;
            debug_mode  <= 1'b0;
            trusted     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= ST_OK;
            rsp_data    <= '0;
            lock_shadow <= 1'b0;
            timeout_err <= 1'b0;
            data_shadow <= '0;
            rsp_cnt     <= '0;
        end else begin
            // strobes and their qualifiers live for a single cycle
            write      <= 1'b0;
            Lock       <= 1'b0;
            debug_mode <= 1'b0;
            trusted    <= 1'b0;
            Data_in    <= '0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state      <= ISSUE;
                        req_ready  <= 1'b0;
                        rsp_data   <= '0;
                        rsp_status <= ST_OK;
                        case (req_op)
                            OP_WRITE: begin
                                if (lock_shadow) begin
                                    rsp_status <= ST_LOCKED;
                                end else begin
                                    write       <= 1'b1;
                                    Data_in     <= req_data;
                                    trusted     <= req_trusted;
                                    data_shadow <= req_data;
                                end
                            end
                            OP_LOCK: begin
                                if (req_trusted) begin
                                    Lock        <= 1'b1;
                                    lock_shadow <= 1'b1;
                                end else begin
                                    rsp_status <= ST_DENIED;
                                end
                            end
                            OP_DBG: begin
                                if (lock_shadow) begin
                                    rsp_status <= ST_LOCKED;
                                end else if (req_trusted && debug_en) begin
                                    write       <= 1'b1;
                                    debug_mode  <= 1'b1;
                                    trusted     <= 1'b1;
                                    Data_in     <= req_data;
                                    data_shadow <= req_data;
                                end else begin
                                    rsp_status <= ST_DENIED;
                                end
                            end
                            OP_READ: rsp_data <= data_shadow;
                        endcase
                    end
                end

                ISSUE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_cnt   <= '0;
                end

                RESP: begin
                    // a handshake on the last allowed cycle still wins over the timeout
                    if (rsp_ready || rsp_cnt == TO_LAST) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        rsp_valid  <= 1'b0;
                        rsp_status <= ST_OK;
                        rsp_data   <= '0;
                        if (!rsp_ready)
                            timeout_err <= 1'b1;
                    end else begin
                        rsp_cnt <= rsp_cnt + 8'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_locked_reg_access_ctrl.sv
// Bench for locked_reg_access_ctrl: directed vector table, reset/timeout sequences and
// random ops scored against an abstract lock/shadow model.
module tb_locked_reg_access_ctrl;

    localparam int DW = 16;

    logic          Clk;
    logic          reset;
    logic          req_valid, req_valid4;
    logic          req_ready, req_ready4;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          req_trusted, debug_en;
    logic [DW-1:0] Data_in, Data_in4;
    logic          write, write4, Lock, Lock4;
    logic          debug_mode, debug_mode4, trusted, trusted4;
    logic          rsp_valid, rsp_valid4, rsp_ready, rsp_ready4;
    logic [1:0]    rsp_status, rsp_status4;
    logic [DW-1:0] rsp_data, rsp_data4;
    logic          lock_shadow, lock_shadow4, timeout_err, timeout_err4;

    locked_reg_access_ctrl #(.DW(DW), .RSP_TIMEOUT(255)) dut (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_trusted(req_trusted), .debug_en(debug_en),
        .Data_in(Data_in), .write(write), .Lock(Lock), .debug_mode(debug_mode), .trusted(trusted),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .lock_shadow(lock_shadow), .timeout_err(timeout_err)
    );

    locked_reg_access_ctrl #(.DW(DW), .RSP_TIMEOUT(4)) dut4 (
        .Clk(Clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_op(req_op), .req_data(req_data), .req_trusted(req_trusted), .debug_en(debug_en),
        .Data_in(Data_in4), .write(write4), .Lock(Lock4), .debug_mode(debug_mode4), .trusted(trusted4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_status(rsp_status4), .rsp_data(rsp_data4),
        .lock_shadow(lock_shadow4), .timeout_err(timeout_err4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic          rst;
        logic [1:0]    op;
        logic [DW-1:0] d;
        logic          tr, de;
        logic [1:0]    st;
        logic          wr, lk, dm, trs;
        logic [DW-1:0] din, rdata;
        logic          ls;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    logic          m_lock;
    logic [DW-1:0] m_shadow;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic rst, logic [1:0] op, logic [DW-1:0] d, logic tr, logic de,
                                logic [1:0] st, logic wr, logic lk, logic dm, logic trs,
                                logic [DW-1:0] din, logic [DW-1:0] rdata, logic ls);
        vec_t v;
        v.rst = rst; v.op = op; v.d = d; v.tr = tr; v.de = de; v.st = st;
        v.wr = wr; v.lk = lk; v.dm = dm; v.trs = trs; v.din = din; v.rdata = rdata; v.ls = ls;
        return v;
    endfunction

    // Spec-level outcome of one op given the current lock and shadow contents.
    function automatic vec_t predict(logic [1:0] op, logic [DW-1:0] d, logic tr, logic de);
        vec_t v;
        v = mk(1'b0, op, d, tr, de, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, m_lock);
        if (op == 2'd0) begin
            if (m_lock) v.st = 2'd1;
            else begin v.wr = 1'b1; v.din = d; v.trs = tr; end
        end else if (op == 2'd1) begin
            if (tr) begin v.lk = 1'b1; v.ls = 1'b1; end
            else v.st = 2'd2;
        end else if (op == 2'd2) begin
            if (m_lock) v.st = 2'd1;
            else if (tr && de) begin v.wr = 1'b1; v.dm = 1'b1; v.trs = 1'b1; v.din = d; end
            else v.st = 2'd2;
        end else begin
            v.rdata = m_shadow;
        end
        return v;
    endfunction

    task automatic reset_dut();
        @(negedge Clk);
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst lock_shadow", 32'(lock_shadow), 32'd0);
        chk("rst timeout_err", 32'(timeout_err), 32'd0);
        chk("rst strobes", {30'd0, write, Lock}, 32'd0);
        chk("rst rsp_status", 32'(rsp_status), 32'd0);
        chk("rst rsp_data", 32'(rsp_data), 32'd0);
        chk("rst Data_in", 32'(Data_in), 32'd0);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        if (!req_ready) chk("req_ready wait", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input int stall);
        @(negedge Clk);
        wait_ready();
        req_valid = 1'b1; req_op = v.op; req_data = v.d; req_trusted = v.tr; debug_en = v.de;
        rsp_ready = (stall == 0);
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        chk("issue write", 32'(write), 32'(v.wr));
        chk("issue Lock", 32'(Lock), 32'(v.lk));
        chk("issue debug_mode", 32'(debug_mode), 32'(v.dm));
        chk("issue trusted", 32'(trusted), 32'(v.trs));
        chk("issue Data_in", 32'(Data_in), 32'(v.din));
        chk("issue lock_shadow", 32'(lock_shadow), 32'(v.ls));
        chk("issue rsp_valid", 32'(rsp_valid), 32'd0);
        chk("issue req_ready", 32'(req_ready), 32'd0);
        @(negedge Clk);
        chk("resp strobes", {30'd0, write, Lock}, 32'd0);
        chk("resp rsp_valid", 32'(rsp_valid), 32'd1);
        chk("resp rsp_status", 32'(rsp_status), 32'(v.st));
        chk("resp rsp_data", 32'(rsp_data), 32'(v.rdata));
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall rsp_status", 32'(rsp_status), 32'(v.st));
            chk("stall rsp_data", 32'(rsp_data), 32'(v.rdata));
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        chk("done rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done req_ready", 32'(req_ready), 32'd1);
        chk("done strobes", {30'd0, write, Lock}, 32'd0);
        chk("done lock_shadow", 32'(lock_shadow), 32'(v.ls));
        rsp_ready = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        vec_t v;
        int   cnt;
        reset = 1'b1; req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
        req_op = 2'd0; req_data = '0; req_trusted = 1'b0; debug_en = 1'b0;

        //          rst   op    data      tr    de    st    wr    lk    dm    trs   din       rdata     ls
        tbl[0]  = mk(1'b1, 2'd0, 16'hA5A5, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 1'b0);
        tbl[1]  = mk(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1'b0);
        tbl[2]  = mk(1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tbl[3]  = mk(1'b0, 2'd2, 16'h00FF, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tbl[4]  = mk(1'b0, 2'd2, 16'h00FF, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tbl[5]  = mk(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1'b0);
        tbl[6]  = mk(1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tbl[7]  = mk(1'b0, 2'd0, 16'h1234, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tbl[8]  = mk(1'b0, 2'd2, 16'h00FF, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tbl[9]  = mk(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1'b1);
        tbl[10] = mk(1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tbl[11] = mk(1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tbl[12] = mk(1'b1, 2'd2, 16'h00FF, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00FF, 16'h0000, 1'b0);
        tbl[13] = mk(1'b0, 2'd0, 16'h5A5A, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A, 16'h0000, 1'b0);
        tbl[14] = mk(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0);

        reset_dut();
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst) reset_dut();
            run_op(tbl[i], i % 3);
        end

        // reset while the response is pending: response vanishes and the lock is forgotten
        reset_dut();
        @(negedge Clk);
        req_valid = 1'b1; req_op = 2'd1; req_trusted = 1'b1; rsp_ready = 1'b0;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        chk("seq lock pulse", 32'(Lock), 32'd1);
        @(negedge Clk);
        chk("seq lock rsp_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk("seq rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("seq rst lock_shadow", 32'(lock_shadow), 32'd0);
        chk("seq rst req_ready", 32'(req_ready), 32'd1);
        @(negedge Clk);
        chk("seq rst rsp_valid2", 32'(rsp_valid), 32'd0);

        // reset during ISSUE of WRITE 0xBEEF: no strobe afterwards, no response, shadow cleared
        req_valid = 1'b1; req_op = 2'd0; req_data = 16'hBEEF; req_trusted = 1'b0; rsp_ready = 1'b1;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        chk("beef write", 32'(write), 32'd0);
        chk("beef rsp_valid", 32'(rsp_valid), 32'd0);
        chk("beef lock_shadow", 32'(lock_shadow), 32'd0);
        @(negedge Clk);
        chk("beef write2", 32'(write), 32'd0);
        chk("beef rsp_valid2", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        run_op(mk(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0), 0);

        // response timeout with RSP_TIMEOUT=4
        reset_dut();
        chk("to4 initial err", 32'(timeout_err4), 32'd0);
        req_valid4 = 1'b1; req_op = 2'd0; req_data = 16'h1111; rsp_ready4 = 1'b0;
        @(posedge Clk);
        #1 req_valid4 = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (rsp_valid4) cnt++;
        end
        chk("to4 rsp_valid cycles", 32'(cnt), 32'd4);
        chk("to4 timeout_err", 32'(timeout_err4), 32'd1);
        chk("to4 req_ready", 32'(req_ready4), 32'd1);

        // ready on the 4th response cycle is still a handshake
        reset_dut();
        req_valid4 = 1'b1; req_op = 2'd3; rsp_ready4 = 1'b0;
        @(posedge Clk);
        #1 req_valid4 = 1'b0;
        repeat (5) @(negedge Clk);
        chk("to4 edge rsp_valid", 32'(rsp_valid4), 32'd1);
        rsp_ready4 = 1'b1;
        @(negedge Clk);
        rsp_ready4 = 1'b0;
        chk("to4 edge done", 32'(rsp_valid4), 32'd0);
        chk("to4 edge no err", 32'(timeout_err4), 32'd0);
        chk("to4 edge req_ready", 32'(req_ready4), 32'd1);

        // random ops against the abstract model
        reset_dut();
        m_lock = 1'b0;
        m_shadow = '0;
        for (int i = 0; i < 300; i++) begin
            logic [1:0]    op;
            logic [DW-1:0] d;
            logic          tr, de;
            if ($urandom_range(0, 24) == 0) begin
                reset_dut();
                m_lock = 1'b0;
                m_shadow = '0;
            end
            op = 2'($urandom_range(0, 3));
            d  = DW'($urandom);
            tr = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            v = predict(op, d, tr, de);
            run_op(v, int'($urandom_range(0, 5)));
            if (v.wr) m_shadow = d;
            if (v.lk) m_lock = 1'b1;
        end
        chk("main timeout_err", 32'(timeout_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
